// File: rtl/nonce_sweep_miner_if.sv
// Handshake between the nonce sweep engine (master) and one external chunk hasher (slave).
interface nonce_sweep_miner_if;
  logic         HashStart_O;
  logic [511:0] HashMsg_O;
  logic [10:0]  HashByteNum_O;
  logic         HashNext_I;
  logic         HashVld_I;
  logic [255:0] HashH_I;

  modport master (output HashStart_O, HashMsg_O, HashByteNum_O,
                  input  HashNext_I, HashVld_I, HashH_I);
  modport slave  (input  HashStart_O, HashMsg_O, HashByteNum_O,
                  output HashNext_I, HashVld_I, HashH_I);
endinterface

// File: rtl/nonce_sweep_miner.sv
// Autonomous double-hash nonce sweeper: builds nonce||header blocks for an external hasher,
// rehashes the digest, and stops on the first nonce meeting target and group conditions.
module nonce_sweep_miner #(
  parameter int NONCE_BYTE_LEN = 24,
  parameter int MAX_HDR_BYTES  = 1000,
  parameter int CNT_W          = 32
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          HdrWe_I,
  input  logic [7:0]                    HdrAddr_I,
  input  logic [31:0]                   HdrData_I,
  input  logic [10:0]                   ByteNum_I,
  input  logic [NONCE_BYTE_LEN*8-1:0]   NonceStart_I,
  input  logic [CNT_W-1:0]              NonceCount_I,
  input  logic [255:0]                  Target_I,
  input  logic [2:0]                    GroupsShift_I,
  input  logic [7:0]                    FromGroup_I,
  input  logic [7:0]                    ToGroup_I,
  input  logic                          Start_I,
  input  logic                          Abort_I,
  nonce_sweep_miner_if.master           hsh,
  output logic                          Busy_O,
  output logic                          Done_O,
  output logic                          Found_O,
  output logic [NONCE_BYTE_LEN*8-1:0]   FoundNonce_O,
  output logic [CNT_W-1:0]              Tried_O
);
  localparam int NB = NONCE_BYTE_LEN * 8;
  localparam int NW = NONCE_BYTE_LEN / 4;
  localparam int HW = MAX_HDR_BYTES / 4;
  localparam int AW = $clog2(HW);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE1, S_FEED1, S_ISSUE2, S_FEED2, S_CHECK, S_DONE} state_e;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_e          state_q;
  logic [5:0]      blk_q;
  logic [NB-1:0]   cur_q, fnonce_q;
  logic [CNT_W-1:0] rem_q, tried_q;
  logic [10:0]     bytenum_q;
  logic [255:0]    h_q;
  logic            vld_q, done_q, found_q;
  logic [31:0]     hdr_q [HW];

  logic            idle_like, hash1, hash2, vld_rise, hit;
  logic [31:0]     nwd [8];
  logic [511:0]    msg;
  logic [9:0]      w, hw;
  logic [11:0]     bidx;
  logic [255:0]    hash;
  logic [15:0]     gmask, tmask, gi;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign hash1     = (state_q == S_ISSUE1) || (state_q == S_FEED1);
  assign hash2     = (state_q == S_ISSUE2) || (state_q == S_FEED2);
  assign vld_rise  = hsh.HashVld_I && !vld_q;

  // Nonce words are the big-endian nonce sliced from the MSB, each byte-swapped into the message.
  for (genvar i = 0; i < 8; i++) begin : g_nw
    if (i < NW) begin : g_on
      assign nwd[i] = bswap(cur_q[NB-1-32*i -: 32]);
    end else begin : g_off
      assign nwd[i] = '0;
    end
  end

  always_comb begin
    msg  = '0;
    w    = '0;
    hw   = '0;
    bidx = '0;
    for (int j = 0; j < 16; j++) begin
      w  = {blk_q, 4'(j)};
      hw = w - 10'(NW);
      if (hash2) begin
        if (blk_q == '0 && j < 8) msg[32*j +: 32] = h_q[32*j +: 32];
      end else if (hash1) begin
        if (w < 10'(NW)) begin
          msg[32*j +: 32] = nwd[w[2:0]];
        end else if (hw < 10'(HW)) begin
          for (int k = 0; k < 4; k++) begin
            bidx = {w, 2'(k)};
            if (bidx < {1'b0, bytenum_q}) msg[32*j+8*k +: 8] = hdr_q[hw[AW-1:0]][8*k +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    hash = '0;
    for (int i = 0; i < 8; i++) hash[255-32*i -: 32] = bswap(h_q[32*i +: 32]);
    gmask = (16'd1 << {GroupsShift_I, 1'b0}) - 16'd1;
    tmask = (16'd1 << GroupsShift_I) - 16'd1;
    gi    = hash[15:0] & gmask;
    hit   = (hash <= Target_I) && ((gi >> GroupsShift_I) == {8'h00, FromGroup_I})
            && ((gi & tmask) == {8'h00, ToGroup_I});
  end

  // Header store is deliberately left out of reset so a job survives a soft reset.
  always_ff @(posedge Clk) begin
    if (HdrWe_I && idle_like && HdrAddr_I < 8'(HW)) hdr_q[HdrAddr_I[AW-1:0]] <= HdrData_I;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;  blk_q   <= '0;  cur_q   <= '0;  fnonce_q <= '0;
      rem_q   <= '0;      tried_q <= '0;  bytenum_q <= '0; h_q     <= '0;
      vld_q   <= 1'b0;    done_q  <= 1'b0; found_q <= 1'b0;
    end else begin
      vld_q <= hsh.HashVld_I;
      if (Abort_I) begin
        state_q <= S_IDLE;
        done_q  <= 1'b0;
        found_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: if (Start_I) begin
            bytenum_q <= ByteNum_I;
            cur_q     <= NonceStart_I;
            rem_q     <= NonceCount_I;
            tried_q   <= '0;
            found_q   <= 1'b0;
            blk_q     <= '0;
            done_q    <= (NonceCount_I == '0);
            state_q   <= (NonceCount_I == '0) ? S_DONE : S_ISSUE1;
          end
          S_ISSUE1: state_q <= S_FEED1;
          S_ISSUE2: state_q <= S_FEED2;
          S_FEED1, S_FEED2: begin
            if (vld_rise) begin
              h_q     <= hsh.HashH_I;
              blk_q   <= '0;
              state_q <= (state_q == S_FEED1) ? S_ISSUE2 : S_CHECK;
            end else if (hsh.HashNext_I && blk_q != '1) begin
              blk_q <= blk_q + 6'd1;
            end
          end
          S_CHECK: begin
            tried_q <= tried_q + 1'b1;
            if (hit) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              found_q  <= 1'b1;
              fnonce_q <= cur_q;
            end else if (rem_q == CNT_W'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              rem_q   <= rem_q - 1'b1;
              cur_q   <= cur_q + 1'b1;
              state_q <= S_ISSUE1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign hsh.HashStart_O   = (state_q == S_ISSUE1) || (state_q == S_ISSUE2);
  assign hsh.HashMsg_O     = msg;
  assign hsh.HashByteNum_O = hash1 ? bytenum_q : (hash2 ? 11'd32 : 11'd0);
  assign Busy_O            = !idle_like;
  assign Done_O            = done_q;
  assign Found_O           = found_q;
  assign FoundNonce_O      = fnonce_q;
  assign Tried_O           = tried_q;
endmodule
